// File: rtl/branch_predictor.sv
// IF-stage branch predictor (direct-mapped BTB with 2-bit counters) plus
// ID-stage resolve: mispredict detection, redirect PC, table training and stats.
module branch_predictor #(
    parameter int IDX_W  = 4,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       fetch_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              res_valid,
    input  logic              res_is_branch,
    input  logic [31:0]       res_pc,
    input  logic              res_taken,
    input  logic [31:0]       res_target,
    input  logic              res_pred_taken,
    input  logic [31:0]       res_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [ENTRIES-1:0][31:0]       tgt_q, tgt_d;
    logic [ENTRIES-1:0][1:0]        ctr_q, ctr_d;
    logic [STAT_W-1:0]              br_cnt_q, br_cnt_d;
    logic [STAT_W-1:0]              mp_cnt_q, mp_cnt_d;

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             f_hit, r_hit;
    logic [31:0]      exp_next, prd_next;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign r_idx = res_pc[IDX_W+1:2];
    assign r_tag = res_pc[31:IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle update is not bypassed
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken  = f_hit && ctr_q[f_idx][1];
    assign pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + 32'd4;

    // Compare full next-PCs so a right direction with a wrong target still redirects
    assign exp_next    = (res_is_branch && res_taken) ? res_target : res_pc + 32'd4;
    assign prd_next    = res_pred_taken ? res_pred_target : res_pc + 32'd4;
    assign mispredict  = res_valid && (exp_next != prd_next);
    assign redirect_pc = exp_next;

    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (res_valid) begin
            if (res_is_branch) begin
                if (r_hit) begin
                    if (res_taken) begin
                        if (ctr_q[r_idx] != 2'b11) ctr_d[r_idx] = ctr_q[r_idx] + 2'd1;
                        tgt_d[r_idx] = res_target;
                    end else if (ctr_q[r_idx] != 2'b00) begin
                        ctr_d[r_idx] = ctr_q[r_idx] - 2'd1;
                    end
                end else if (res_taken) begin
                    valid_d[r_idx] = 1'b1;
                    tag_d[r_idx]   = r_tag;
                    tgt_d[r_idx]   = res_target;
                    ctr_d[r_idx]   = 2'b10;
                end
            end else if (r_hit) begin
                // A non-branch matching an entry means the entry is stale
                valid_d[r_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (res_valid && res_is_branch && (br_cnt_q != {STAT_W{1'b1}}))
            br_cnt_d = br_cnt_q + 1'b1;
        if (mispredict && (mp_cnt_q != {STAT_W{1'b1}}))
            mp_cnt_d = mp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            tag_q    <= '0;
            tgt_q    <= '0;
            ctr_q    <= {ENTRIES{2'b01}};
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            tgt_q    <= tgt_d;
            ctr_q    <= ctr_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus random checks of branch_predictor against a table-level reference model.
module tb_branch_predictor;
    localparam int IDX_W    = 4;
    localparam int STAT_W   = 6;
    localparam int ENTRIES  = 1 << IDX_W;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       fetch_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              res_valid, res_is_branch, res_taken, res_pred_taken;
    logic [31:0]       res_pc, res_target, res_pred_target;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] stat_branches, stat_mispredicts;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_br, m_mp;

    branch_predictor #(.IDX_W(IDX_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_idx(logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned m_tg(logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_br = 0; m_mp = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int unsigned i;
        i  = m_idx(pc);
        tk = m_valid[i] && (m_tag[i] == m_tg(pc)) && (m_ctr[i] >= 2);
        tg = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_train();
        int unsigned i;
        bit hit;
        i   = m_idx(res_pc);
        hit = m_valid[i] && (m_tag[i] == m_tg(res_pc));
        if (res_is_branch) begin
            if (hit) begin
                m_ctr[i] = res_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                     : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (res_taken) m_tgt[i] = res_target;
            end else if (res_taken) begin
                m_valid[i] = 1; m_tag[i] = m_tg(res_pc); m_tgt[i] = res_target; m_ctr[i] = 2;
            end
        end else if (hit) begin
            m_valid[i] = 0;
        end
    endtask

    // Inputs are set just after a negedge; compare, clock once, advance the model.
    task automatic cycle();
        logic        e_pt, e_mp;
        logic [31:0] e_ptg, en, pn;
        #1;
        model_pred(fetch_pc, e_pt, e_ptg);
        en   = (res_is_branch && res_taken) ? res_target : res_pc + 32'd4;
        pn   = res_pred_taken ? res_pred_target : res_pc + 32'd4;
        e_mp = res_valid && (en != pn);
        check("pred_taken", {31'b0, pred_taken}, {31'b0, e_pt});
        check("pred_target", pred_target, e_ptg);
        check("mispredict", {31'b0, mispredict}, {31'b0, e_mp});
        if (e_mp) check("redirect_pc", redirect_pc, en);
        check("stat_branches", 32'(stat_branches), 32'(m_br));
        check("stat_mispredicts", 32'(stat_mispredicts), 32'(m_mp));
        @(posedge clk);
        if (res_valid) begin
            model_train();
            if (res_is_branch && m_br < STAT_MAX) m_br++;
            if (e_mp && m_mp < STAT_MAX) m_mp++;
        end
        @(negedge clk);
    endtask

    task automatic resolve(input logic br, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        res_valid = 1'b1; res_is_branch = br; res_pc = pc; res_taken = tk;
        res_target = tgt; res_pred_taken = ptk; res_pred_target = ptgt;
    endtask

    task automatic idle();
        res_valid = 1'b0; res_is_branch = 1'b0; res_taken = 1'b0; res_pred_taken = 1'b0;
    endtask

    initial begin
        logic        ptk;
        logic [31:0] ptg;
        rst_n = 1'b0; idle();
        res_pc = '0; res_target = '0; res_pred_target = '0;
        fetch_pc = 32'h0040_0010;
        model_reset();
        #1;
        check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h0040_0014);
        check("rst_stat_br", 32'(stat_branches), 32'd0);
        check("rst_stat_mp", 32'(stat_mispredicts), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // allocate on taken miss
        resolve(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0);
        #1;
        check("alloc_mp", {31'b0, mispredict}, 32'd1);
        check("alloc_redirect", redirect_pc, 32'h0040_0100);
        cycle();
        idle(); #1;
        check("alloc_pred_taken", {31'b0, pred_taken}, 32'd1);
        check("alloc_pred_target", pred_target, 32'h0040_0100);
        cycle();

        // counter decrement 10->01->00 then four taken to 11
        resolve(1, 32'h0040_0010, 0, 32'h0040_0100, 1, 32'h0040_0100);
        #1;
        check("nt1_mp", {31'b0, mispredict}, 32'd1);
        check("nt1_redirect", redirect_pc, 32'h0040_0014);
        cycle();
        resolve(1, 32'h0040_0010, 0, 32'h0040_0100, 0, 32'h0040_0014);
        #1; check("nt2_mp", {31'b0, mispredict}, 32'd0);
        cycle();
        for (int k = 0; k < 4; k++) begin
            resolve(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0);
            cycle();
        end
        resolve(1, 32'h0040_0010, 0, 32'h0040_0100, 1, 32'h0040_0100);
        cycle();
        idle(); #1;
        check("sat_hi_still_taken", {31'b0, pred_taken}, 32'd1);
        cycle();

        // alias non-branch with different tag keeps entry; matching one invalidates
        resolve(0, 32'h0040_0050, 0, 32'h0, 0, 32'h0);
        cycle();
        idle(); #1;
        check("alias_kept", {31'b0, pred_taken}, 32'd1);
        cycle();
        resolve(0, 32'h0040_0010, 0, 32'h0, 1, 32'h0040_0100);
        #1;
        check("stale_mp", {31'b0, mispredict}, 32'd1);
        check("stale_redirect", redirect_pc, 32'h0040_0014);
        cycle();
        idle(); #1;
        check("stale_invalid", {31'b0, pred_taken}, 32'd0);
        cycle();

        // same-index fetch and resolve: no bypass
        resolve(1, 32'h0040_0010, 1, 32'h0040_0200, 0, 32'h0);
        #1; check("nobypass_old", {31'b0, pred_taken}, 32'd0);
        cycle();
        idle(); #1;
        check("nobypass_new", pred_target, 32'h0040_0200);
        cycle();

        // mid-stream asynchronous reset
        resolve(1, 32'h0040_0020, 1, 32'h0040_0300, 0, 32'h0);
        cycle(); idle();
        #2; rst_n = 1'b0; #1;
        check("mid_rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("mid_rst_pred_target", pred_target, 32'h0040_0014);
        check("mid_rst_stat_br", 32'(stat_branches), 32'd0);
        check("mid_rst_mp", {31'b0, mispredict}, 32'd0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;

        // wrap-around
        fetch_pc = 32'hFFFF_FFFC;
        resolve(1, 32'hFFFF_FFFC, 1, 32'h0000_0000, 0, 32'h0);
        #1;
        check("wrap_pred_target", pred_target, 32'h0000_0000);
        check("wrap_no_mp", {31'b0, mispredict}, 32'd0);
        cycle();

        // drive statistics into saturation
        for (int k = 0; k < STAT_MAX + 8; k++) begin
            resolve(1, 32'h0000_1000, 1, 32'h0000_2000, 1, 32'h0000_3000);
            cycle();
        end
        idle(); #1;
        check("stat_mp_sat", 32'(stat_mispredicts), 32'(STAT_MAX));
        check("stat_br_sat", 32'(stat_branches), 32'(STAT_MAX));
        cycle();

        // random phase, fresh from reset so the stats move again
        rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            fetch_pc      = {($urandom_range(0, 1) != 0) ? 24'h004000 : 24'h100000,
                             6'($urandom_range(0, 63)), 2'b00};
            res_valid     = ($urandom_range(0, 3) != 0);
            res_is_branch = ($urandom_range(0, 4) != 0);
            res_pc        = {($urandom_range(0, 1) != 0) ? 24'h004000 : 24'h100000,
                             6'($urandom_range(0, 63)), 2'b00};
            res_taken     = $urandom_range(0, 1) != 0;
            res_target    = {16'h0040, 14'($urandom), 2'b00};
            model_pred(res_pc, ptk, ptg);
            if ($urandom_range(0, 3) != 0) begin
                res_pred_taken = ptk; res_pred_target = ptg;
            end else begin
                res_pred_taken = $urandom_range(0, 1) != 0;
                res_pred_target = $urandom;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
